// File: rtl/md_unit_if.sv
// Bundle of the EX-stage mul/div request signals and the HI/LO result side.
// The pipeline drives the master side and md_unit sits on the slave side.
interface md_if;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, MDUOp, A, B, Flush,
        input  Busy, Stall, Done, HI, LO
    );

    modport slave (
        input  Start, MDUOp, A, B, Flush,
        output Busy, Stall, Done, HI, LO
    );
endinterface

// File: rtl/md_unit.sv
// Iterative 32-bit multiply/divide unit owning the architectural HI/LO registers.
// Runs on operand magnitudes, one shift-add or shift-subtract step per cycle, with signs applied in FIX.
module md_unit #(
    parameter int ITER = 32
) (
    input  logic clk,
    input  logic rstn,
    md_if.slave  mdu
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        mul_q, neg_q, rneg_q, div0_q;
    logic [31:0] a_q, b_q;
    logic [63:0] acc_q;

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    logic is_md, is_signed, accept, last_iter;

    assign is_md     = (mdu.MDUOp >= OP_MULT) && (mdu.MDUOp <= OP_DIVU);
    assign is_signed = (mdu.MDUOp == OP_MULT) || (mdu.MDUOp == OP_DIV);
    assign accept    = (state_q == S_IDLE) && mdu.Start && !mdu.Flush;
    assign last_iter = (cnt_q == 6'(ITER - 1));

    // acc_q holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] div_next;
    logic [63:0] prod;
    logic [31:0] quo, rem;

    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        div_shift = {acc_q[63:32], acc_q[31]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_sub   = div_shift[31:0] - b_q;
        div_next  = div_ge ? {div_sub, acc_q[30:0], 1'b1}
                           : {div_shift[31:0], acc_q[30:0], 1'b0};
        prod      = cond_neg64(acc_q, neg_q);
        quo       = div0_q ? 32'hFFFF_FFFF : cond_neg32(acc_q[31:0], neg_q);
        rem       = div0_q ? a_q : cond_neg32(acc_q[63:32], rneg_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept && is_md) state_d = S_CALC;
            S_CALC: begin
                if (mdu.Flush)     state_d = S_IDLE;
                else if (last_iter) state_d = S_FIX;
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = '0;
        done_d = 1'b0;
        hi_d   = hi_q;
        lo_d   = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && mdu.MDUOp == OP_MTHI) hi_d = mdu.A;
                if (accept && mdu.MDUOp == OP_MTLO) lo_d = mdu.A;
            end
            S_CALC: cnt_d = cnt_q + 6'd1;
            S_FIX: begin
                if (!mdu.Flush) begin
                    done_d = 1'b1;
                    if (mul_q) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= done_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    // Operand latch and iteration datapath carry no reset; they are only read after a Start.
    always_ff @(posedge clk) begin
        if (accept && is_md) begin
            mul_q  <= (mdu.MDUOp == OP_MULT) || (mdu.MDUOp == OP_MULTU);
            neg_q  <= is_signed & (mdu.A[31] ^ mdu.B[31]);
            rneg_q <= is_signed & mdu.A[31];
            div0_q <= (mdu.B == 32'd0);
            a_q    <= mdu.A;
            b_q    <= cond_neg32(mdu.B, is_signed & mdu.B[31]);
            acc_q  <= {32'd0, cond_neg32(mdu.A, is_signed & mdu.A[31])};
        end else if (state_q == S_CALC) begin
            acc_q  <= mul_q ? mul_next : div_next;
        end
    end

    assign mdu.Busy  = (state_q != S_IDLE);
    assign mdu.Stall = mdu.Busy | (mdu.Start & is_md);
    assign mdu.Done  = done_q;
    assign mdu.HI    = hi_q;
    assign mdu.LO    = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Randomised scoreboard bench for md_unit: expected HI/LO and Done cycle are queued at issue
// and checked by an independent monitor whenever Done is seen.
module tb_md_unit;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    md_if mdu();

    md_unit dut (
        .clk  (clk),
        .rstn (rstn),
        .mdu  (mdu)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic, SV signed division truncates toward zero.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t               e;
        logic signed [63:0] sa, sb, q, r;
        logic [63:0]        p;
        sa = $signed(a);
        sb = $signed(b);
        e.hi = '0; e.lo = '0; e.cyc = 0;
        case (op)
            3'b001: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'b010: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'b011: begin
                if (b == 0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; end
                else begin q = sa / sb; r = sa % sb; e.hi = r[31:0]; e.lo = q[31:0]; end
            end
            3'b100: begin
                if (b == 0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; end
                else begin e.hi = a % b; e.lo = a / b; end
            end
            default: ;
        endcase
        return e;
    endfunction

    exp_t mon_e;
    initial forever begin
        @(negedge clk);
        if (rstn && mdu.Done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Done=1 at cycle %0d expected no Done", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("result_hilo", {mdu.HI, mdu.LO}, {mon_e.hi, mon_e.lo});
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1ns after an edge; returns 1ns after the accepting edge with Start dropped.
    task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic exp_stall);
        mdu.Start = 1'b1; mdu.MDUOp = op; mdu.A = a; mdu.B = b;
        #1;
        chk("stall_in_start_cycle", 64'(mdu.Stall), 64'(exp_stall));
        step();
        mdu.Start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (mdu.Busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        e = model(op, a, b);
        e.cyc = cyc + 34;
        sbq.push_back(e);
        drive_start(op, a, b, 1'b1);
        wait_idle(n);
        chk("busy_cycles", 64'(n), 64'd33);
        hi_m = e.hi;
        lo_m = e.lo;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        drive_start(op, a, 32'd0, 1'b0);
        if (op == 3'b101) hi_m = a;
        if (op == 3'b110) lo_m = a;
        chk("mt_busy", 64'(mdu.Busy), 64'd0);
        chk("mt_hilo", {mdu.HI, mdu.LO}, {hi_m, lo_m});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        mdu.Start = 1'b0; mdu.MDUOp = 3'b000; mdu.A = '0; mdu.B = '0; mdu.Flush = 1'b0;
        repeat (3) step();
        chk("reset_state", {mdu.HI, mdu.LO}, 64'd0);
        chk("reset_ctrl", {62'd0, mdu.Busy, mdu.Done}, 64'd0);
        rstn = 1'b1;
        step();

        // Asynchronous reset in the middle of CALC.
        mt(3'b101, 32'hAAAA_5555);
        mt(3'b110, 32'h5555_AAAA);
        drive_start(3'b010, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        repeat (10) step();
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_hilo", {mdu.HI, mdu.LO}, 64'd0);
        chk("async_rst_ctrl", {62'd0, mdu.Busy, mdu.Done}, 64'd0);
        hi_m = '0; lo_m = '0;
        step();
        rstn = 1'b1;
        step();

        // Directed cases, issued back-to-back.
        run_md(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md(3'b001, 32'hFFFF_FFFD, 32'd7);
        run_md(3'b011, 32'hFFFF_FFF9, 32'd2);
        run_md(3'b100, 32'd100, 32'd7);
        run_md(3'b011, 32'd5, 32'd0);
        run_md(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md(3'b011, 32'hFFFF_FFF9, 32'd0);

        // MTHI while busy is dropped; MTLO afterwards lands next cycle.
        begin
            exp_t e;
            e = model(3'b010, 32'd3, 32'd5);
            e.cyc = cyc + 34;
            sbq.push_back(e);
            drive_start(3'b010, 32'd3, 32'd5, 1'b1);
            repeat (3) step();
            drive_start(3'b101, 32'h1234_5678, 32'd0, 1'b1);
            wait_idle(n);
            hi_m = e.hi; lo_m = e.lo;
            chk("mthi_ignored_hi", 64'(mdu.HI), 64'(e.hi));
        end
        mt(3'b110, 32'hCAFE_BABE);

        // Flush mid-CALC and in FIX leaves HI/LO alone and emits no Done.
        mt(3'b101, 32'd1);
        mt(3'b110, 32'd2);
        drive_start(3'b010, $urandom, $urandom, 1'b1);
        repeat (9) step();
        mdu.Flush = 1'b1;
        step();
        mdu.Flush = 1'b0;
        chk("flush_calc_busy", 64'(mdu.Busy), 64'd0);
        chk("flush_calc_hilo", {mdu.HI, mdu.LO}, {32'd1, 32'd2});
        drive_start(3'b011, $urandom, 32'd3, 1'b1);
        repeat (32) step();
        mdu.Flush = 1'b1;
        step();
        mdu.Flush = 1'b0;
        chk("flush_fix_busy", 64'(mdu.Busy), 64'd0);
        repeat (3) step();
        chk("flush_fix_hilo", {mdu.HI, mdu.LO}, {32'd1, 32'd2});

        // Start with Flush in IDLE is ignored; an undefined opcode is a no-op.
        mdu.Flush = 1'b1;
        drive_start(3'b101, 32'hDEAD_BEEF, 32'd0, 1'b0);
        mdu.Flush = 1'b0;
        chk("flush_idle_hi", 64'(mdu.HI), 64'd1);
        drive_start(3'b111, 32'hDEAD_BEEF, 32'd9, 1'b0);
        chk("noop_busy", 64'(mdu.Busy), 64'd0);
        chk("noop_hilo", {mdu.HI, mdu.LO}, {32'd1, 32'd2});

        // Randomised mix, back-to-back.
        for (int i = 0; i < 24; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(1, 4));
            run_md(op, pick(), pick());
        end

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            n++;
            step();
        end
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        chk("final_hilo", {mdu.HI, mdu.LO}, {hi_m, lo_m});
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
